// File: rtl/gate_unit_arbiter.sv
// Four-requester round-robin arbiter in front of one shared WIDTH-bit AND/OR/NOT/XOR unit.
// Each granted operation takes three cycles: latch (IDLE), evaluate (EXEC), report (DONE).
module gate_unit_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               iClk,
  input  logic               iRst,
  input  logic [3:0]         iReq,
  input  logic [7:0]         iOp,
  input  logic [4*WIDTH-1:0] iA,
  input  logic [4*WIDTH-1:0] iB,
  output logic [3:0]         oGnt,
  output logic [1:0]         oGntId,
  output logic               oValid,
  output logic [WIDTH-1:0]   oResult,
  output logic               oBusy
);

  // Handshake: requester k holds iReq[k] high with iOp/iA/iB slice k stable until it
  // sees oGnt[k] (a one-cycle pulse together with oValid/oResult), then drops iReq[k].
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [1:0]         ptr_q;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [3:0]         gnt_q;
  logic [1:0]         gnt_id_q;
  logic               valid_q;
  logic [WIDTH-1:0]   result_q;
  logic               busy_q;

  logic               win_found;
  logic [1:0]         win_id;
  logic [1:0]         cand;
  logic [1:0]         win_op;
  logic [WIDTH-1:0]   win_a;
  logic [WIDTH-1:0]   win_b;
  logic [WIDTH-1:0]   result_d;

  // Scan starts at ptr_q so the requester just served is considered last.
  always_comb begin
    win_found = 1'b0;
    win_id    = 2'd0;
    cand      = 2'd0;
    for (int i = 0; i < 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!win_found && iReq[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  always_comb begin
    win_op = 2'd0;
    win_a  = '0;
    win_b  = '0;
    for (int k = 0; k < 4; k++) begin
      if (win_id == 2'(k)) begin
        win_op = iOp[2*k +: 2];
        win_a  = iA[WIDTH*k +: WIDTH];
        win_b  = iB[WIDTH*k +: WIDTH];
      end
    end
  end

  always_comb begin
    case (op_q)
      2'b00:   result_d = a_q & b_q;
      2'b01:   result_d = a_q | b_q;
      2'b10:   result_d = ~a_q;
      default: result_d = a_q ^ b_q;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q  <= IDLE;
      ptr_q    <= 2'd0;
      op_q     <= 2'd0;
      a_q      <= '0;
      b_q      <= '0;
      gnt_q    <= 4'd0;
      gnt_id_q <= 2'd0;
      valid_q  <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      gnt_q   <= 4'd0;
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_found) begin
            op_q     <= win_op;
            a_q      <= win_a;
            b_q      <= win_b;
            gnt_id_q <= win_id;
            busy_q   <= 1'b1;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          result_q <= result_d;
          state_q  <= DONE;
        end
        DONE: begin
          // Strobe lands in the following IDLE cycle, so oBusy already reads low.
          valid_q <= 1'b1;
          gnt_q   <= 4'b0001 << gnt_id_q;
          ptr_q   <= gnt_id_q + 2'd1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign oGnt    = gnt_q;
  assign oGntId  = gnt_id_q;
  assign oValid  = valid_q;
  assign oResult = result_q;
  assign oBusy   = busy_q;

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Self-checking bench for gate_unit_arbiter: directed scenarios followed by random
// operations checked against a round-robin/opcode reference model.
module tb_gate_unit_arbiter;
  localparam int W = 8;

  logic             iClk;
  logic             iRst;
  logic [3:0]       iReq;
  logic [7:0]       iOp;
  logic [4*W-1:0]   iA;
  logic [4*W-1:0]   iB;
  logic [3:0]       oGnt;
  logic [1:0]       oGntId;
  logic             oValid;
  logic [W-1:0]     oResult;
  logic             oBusy;

  int n_checks = 0;
  int n_pass   = 0;
  int m_ptr    = 0;
  int m_last   = 0;

  gate_unit_arbiter #(.WIDTH(W)) dut (
    .iClk    (iClk),
    .iRst    (iRst),
    .iReq    (iReq),
    .iOp     (iOp),
    .iA      (iA),
    .iB      (iB),
    .oGnt    (oGnt),
    .oGntId  (oGntId),
    .oValid  (oValid),
    .oResult (oResult),
    .oBusy   (oBusy)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int ref_winner(input logic [3:0] req, input int p);
    for (int i = 0; i < 4; i++)
      if (req[(p + i) % 4]) return (p + i) % 4;
    return -1;
  endfunction

  function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return ~a;
      default: return a ^ b;
    endcase
  endfunction

  task automatic do_reset(input string tag);
    iRst = 1'b1;
    @(posedge iClk); #1;
    iRst = 1'b0;
    m_ptr  = 0;
    m_last = 0;
    check({tag, "_gnt"},    32'(oGnt),    32'd0);
    check({tag, "_gntid"},  32'(oGntId),  32'd0);
    check({tag, "_valid"},  32'(oValid),  32'd0);
    check({tag, "_result"}, 32'(oResult), 32'd0);
    check({tag, "_busy"},   32'(oBusy),   32'd0);
  endtask

  // Called #1 after a rising edge with the DUT in IDLE; leaves time #1 after the edge
  // on which the strobe appears, so the next call's inputs meet the next IDLE sample.
  task automatic do_op(input string tag, input logic [3:0] req, input logic [7:0] op,
                       input logic [4*W-1:0] a, input logic [4*W-1:0] b, input bit disturb);
    int k;
    logic [W-1:0] exp_res;
    iReq = req; iOp = op; iA = a; iB = b;
    k = ref_winner(req, m_ptr);
    if (k < 0) begin
      @(posedge iClk); #1;
      check({tag, "_idle_busy"},  32'(oBusy),  32'd0);
      check({tag, "_idle_valid"}, 32'(oValid), 32'd0);
      check({tag, "_idle_gntid"}, 32'(oGntId), 32'(m_last));
      return;
    end
    exp_res = ref_op(op[2*k +: 2], a[W*k +: W], b[W*k +: W]);
    @(posedge iClk); #1;
    check({tag, "_exec_busy"},  32'(oBusy),  32'd1);
    check({tag, "_exec_valid"}, 32'(oValid), 32'd0);
    check({tag, "_exec_gntid"}, 32'(oGntId), 32'(k));
    if (disturb) begin
      iReq = 4'($urandom); iOp = 8'($urandom);
      iA = (4*W)'($urandom); iB = (4*W)'($urandom);
    end
    @(posedge iClk); #1;
    check({tag, "_done_busy"},  32'(oBusy),  32'd1);
    check({tag, "_done_gnt"},   32'(oGnt),   32'd0);
    @(posedge iClk); #1;
    check({tag, "_valid"},  32'(oValid),  32'd1);
    check({tag, "_gnt"},    32'(oGnt),    32'(4'b0001 << k));
    check({tag, "_result"}, 32'(oResult), 32'(exp_res));
    check({tag, "_gntid"},  32'(oGntId),  32'(k));
    check({tag, "_busy"},   32'(oBusy),   32'd0);
    m_ptr  = (k + 1) % 4;
    m_last = k;
    iReq = 4'd0;
  endtask

  initial begin
    iRst = 1'b1; iReq = 4'd0; iOp = 8'd0; iA = '0; iB = '0;
    @(posedge iClk); #1;
    do_reset("rst");

    // Single request, AND on requester 0.
    do_op("t1_and", 4'b0001, 8'h00, 32'h0000_00F0, 32'h0000_003C, 1'b0);

    // Every opcode on requester 2 (A=A5, B=0F).
    do_op("t2_and", 4'b0100, 8'b0000_0000, 32'h00A5_0000, 32'h000F_0000, 1'b0);
    do_op("t2_or",  4'b0100, 8'b0001_0000, 32'h00A5_0000, 32'h000F_0000, 1'b0);
    do_op("t2_not", 4'b0100, 8'b0010_0000, 32'h00A5_0000, 32'h000F_0000, 1'b0);
    do_op("t2_xor", 4'b0100, 8'b0011_0000, 32'h00A5_0000, 32'h000F_0000, 1'b0);

    // All four requesting: order 0,1,2,3,0 back to back.
    do_reset("t3_rst");
    for (int i = 0; i < 5; i++)
      do_op($sformatf("t3_rr%0d", i), 4'b1111, 8'b1110_0100, 32'h3C5A_F00F,
            32'hFF0F_33C3, 1'b0);

    // Wrap after requester 3, then fairness between 0 and 3.
    do_reset("t4_rst");
    do_op("t4_r3",  4'b1000, 8'hC0, 32'h7700_0000, 32'h0F00_0000, 1'b0);
    do_op("t4_r0",  4'b1001, 8'h41, 32'h1200_0034, 32'h5600_0078, 1'b0);
    do_op("t4_r3b", 4'b1001, 8'h41, 32'h1200_0034, 32'h5600_0078, 1'b0);

    // Operand change during EXEC must not reach the result.
    do_reset("t5_rst");
    do_op("t5_hold", 4'b0010, 8'b0000_0100, 32'h0000_1100, 32'h0000_2200, 1'b1);

    // Reset during EXEC aborts the op; pointer restarts at 0.
    do_op("t6_pre", 4'b0100, 8'h10, 32'h0055_0000, 32'h00AA_0000, 1'b0);
    iReq = 4'b1000; iOp = 8'hC0; iA = 32'h8100_0000; iB = 32'h1800_0000;
    @(posedge iClk); #1;
    check("t6_exec_busy", 32'(oBusy), 32'd1);
    do_reset("t6_abort");
    iReq = 4'd0;
    @(posedge iClk); #1;
    check("t6_no_valid", 32'(oValid), 32'd0);
    check("t6_no_gnt",   32'(oGnt),   32'd0);
    do_op("t6_after", 4'b1111, 8'h1B, 32'hDEAD_BEEF, 32'h0123_4567, 1'b0);

    // Random traffic, including idle cycles and mid-op disturbance.
    for (int n = 0; n < 300; n++) begin
      logic [3:0] rq;
      rq = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
      do_op("rnd", rq, 8'($urandom), (4*W)'($urandom), (4*W)'($urandom),
            1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
